// File: rtl/mul_pkg.sv
// ============================================================================
// Module   : mul_pkg
// Purpose  : Shared encodings for the iterative multiplier and its controller.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package mul_pkg;

  localparam int MUL_ITER = 32;

  typedef enum logic [1:0] {
    MUL_OP   = 2'b00,
    MLA_OP   = 2'b01,
    UMULL_OP = 2'b10,
    SMULL_OP = 2'b11
  } mul_cmd_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    FIX  = 2'b10,
    DONE = 2'b11
  } mul_state_e;

endpackage

`default_nettype wire

// File: rtl/mul_unit.sv
// ============================================================================
// Module   : mul_unit
// Purpose  : Radix-2 shift-add multiplier for MUL/MLA/UMULL/SMULL, fixed latency.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module mul_unit
  import mul_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             Start,
  input  logic [1:0]       MulCmd,
  input  logic [WIDTH-1:0] SrcA,
  input  logic [WIDTH-1:0] SrcB,
  input  logic [WIDTH-1:0] Acc,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] ResultLo,
  output logic [WIDTH-1:0] ResultHi,
  output logic [3:0]       MulFlags
);

  localparam int CNT_W = $clog2(MUL_ITER);

  mul_state_e         state_q, state_d;
  mul_cmd_e           cmd_q, cmd_d;
  logic [WIDTH-1:0]   acc_q, acc_d;
  logic               neg_q, neg_d;
  logic [2*WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [2*WIDTH-1:0] prod_q, prod_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               last_q, last_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [3:0]         flags_q, flags_d;

  logic [WIDTH-1:0]   abs_a, abs_b;
  logic [2*WIDTH-1:0] fix_prod;
  logic               fix_n, fix_z;

  always_comb begin
    state_d  = state_q;
    cmd_d    = cmd_q;
    acc_d    = acc_q;
    neg_d    = neg_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    prod_d   = prod_q;
    cnt_d    = cnt_q;
    last_d   = last_q;
    lo_d     = lo_q;
    hi_d     = hi_q;
    flags_d  = flags_q;
    // 0x80000000 negates to itself, which is the correct unsigned magnitude
    abs_a    = SrcA[WIDTH-1] ? (~SrcA + 1'b1) : SrcA;
    abs_b    = SrcB[WIDTH-1] ? (~SrcB + 1'b1) : SrcB;
    fix_prod = neg_q ? (~prod_q + 1'b1) : prod_q;
    fix_n    = 1'b0;
    fix_z    = 1'b0;

    case (state_q)
      IDLE: begin
        if (Start) begin
          state_d = RUN;
          cmd_d   = mul_cmd_e'(MulCmd);
          acc_d   = Acc;
          prod_d  = '0;
          cnt_d   = '0;
          last_d  = 1'b0;
          if (mul_cmd_e'(MulCmd) == SMULL_OP) begin
            mcand_d  = {{WIDTH{1'b0}}, abs_a};
            mplier_d = abs_b;
            neg_d    = SrcA[WIDTH-1] ^ SrcB[WIDTH-1];
          end else begin
            mcand_d  = {{WIDTH{1'b0}}, SrcA};
            mplier_d = SrcB;
            neg_d    = 1'b0;
          end
        end
      end

      RUN: begin
        // one idle RUN cycle after the final iteration keeps Start-to-Done at 35
        if (last_q) begin
          state_d = FIX;
        end else begin
          if (mplier_q[0]) begin
            prod_d = prod_q + mcand_q;
          end
          mcand_d  = mcand_q << 1;
          mplier_d = mplier_q >> 1;
          cnt_d    = cnt_q + 1'b1;
          if (cnt_q == CNT_W'(MUL_ITER - 1)) begin
            last_d = 1'b1;
          end
        end
      end

      FIX: begin
        state_d = DONE;
        case (cmd_q)
          MUL_OP: begin
            lo_d = fix_prod[WIDTH-1:0];
            hi_d = '0;
          end
          MLA_OP: begin
            lo_d = fix_prod[WIDTH-1:0] + acc_q;
            hi_d = '0;
          end
          default: begin
            lo_d = fix_prod[WIDTH-1:0];
            hi_d = fix_prod[2*WIDTH-1:WIDTH];
          end
        endcase
        if (cmd_q == UMULL_OP || cmd_q == SMULL_OP) begin
          fix_n = hi_d[WIDTH-1];
          fix_z = ({hi_d, lo_d} == '0);
        end else begin
          fix_n = lo_d[WIDTH-1];
          fix_z = (lo_d == '0);
        end
        flags_d = {fix_n, fix_z, 2'b00};
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      cmd_q    <= MUL_OP;
      acc_q    <= '0;
      neg_q    <= 1'b0;
      mcand_q  <= '0;
      mplier_q <= '0;
      prod_q   <= '0;
      cnt_q    <= '0;
      last_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      lo_q     <= '0;
      hi_q     <= '0;
      flags_q  <= '0;
    end else begin
      state_q  <= state_d;
      cmd_q    <= cmd_d;
      acc_q    <= acc_d;
      neg_q    <= neg_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      prod_q   <= prod_d;
      cnt_q    <= cnt_d;
      last_q   <= last_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      lo_q     <= lo_d;
      hi_q     <= hi_d;
      flags_q  <= flags_d;
    end
  end

  assign Busy     = busy_q;
  assign Done     = done_q;
  assign ResultLo = lo_q;
  assign ResultHi = hi_q;
  assign MulFlags = flags_q;

endmodule

`default_nettype wire

// File: tb/tb_mul_unit.sv
// ============================================================================
// Module   : tb_mul_unit
// Purpose  : Self-checking bench for mul_unit against an arithmetic reference.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_mul_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        Start = 1'b0;
  logic [1:0]  MulCmd = 2'b00;
  logic [31:0] SrcA = '0;
  logic [31:0] SrcB = '0;
  logic [31:0] Acc = '0;
  logic        Busy;
  logic        Done;
  logic [31:0] ResultLo;
  logic [31:0] ResultHi;
  logic [3:0]  MulFlags;

  int compared = 0;
  int mismatched = 0;
  bit chk_en = 1'b0;

  mul_unit #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .Start(Start), .MulCmd(MulCmd),
    .SrcA(SrcA), .SrcB(SrcB), .Acc(Acc), .Busy(Busy), .Done(Done),
    .ResultLo(ResultLo), .ResultHi(ResultHi), .MulFlags(MulFlags)
  );

  always #5 clk = ~clk;

  // Returns {N,Z,C,V, hi[31:0], lo[31:0]}
  function automatic logic [67:0] model_op(input logic [1:0] cmd, input logic [31:0] a,
                                           input logic [31:0] b, input logic [31:0] acc);
    logic [63:0] p;
    logic [31:0] lo, hi;
    logic        n, z;
    case (cmd)
      2'b00: begin lo = a * b;       hi = '0; end
      2'b01: begin lo = a * b + acc; hi = '0; end
      2'b10: begin p = {32'b0, a} * {32'b0, b}; lo = p[31:0]; hi = p[63:32]; end
      default: begin
        p  = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
        lo = p[31:0];
        hi = p[63:32];
      end
    endcase
    if (cmd[1]) begin n = hi[31]; z = ({hi, lo} == 64'd0); end
    else        begin n = lo[31]; z = (lo == 32'd0); end
    return {n, z, 2'b00, hi, lo};
  endfunction

  task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Reference: countdown of cycles remaining in the current operation
  int          rem = 0;
  logic [67:0] pend = '0;
  logic [67:0] expv = '0;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      rem  = 0;
      expv = '0;
    end else if (rem == 0) begin
      if (Start) begin
        rem  = 35;
        pend = model_op(MulCmd, SrcA, SrcB, Acc);
      end
    end else begin
      rem = rem - 1;
      if (rem == 1) expv = pend;
    end
  end

  always @(posedge clk) begin
    #1;
    if (chk_en) begin
      check("busy", 72'(Busy), 72'(rem != 0));
      check("done", 72'(Done), 72'(rem == 1));
      check("result", 72'({ResultHi, ResultLo}), 72'(expv[63:0]));
      check("flags", 72'(MulFlags), 72'(expv[67:64]));
    end
  end

  task automatic run_op(input logic [1:0] cmd, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] acc, input bit glitch,
                        output int lat, output int ndone);
    int n;
    @(negedge clk);
    Start = 1'b1; MulCmd = cmd; SrcA = a; SrcB = b; Acc = acc;
    lat = 0; ndone = 0; n = 0;
    while (n < 60) begin
      @(negedge clk);
      n++;
      Start = glitch && (n == 5 || n == 20);
      if (Start) begin
        MulCmd = 2'($urandom_range(0, 3)); SrcA = $urandom; SrcB = $urandom; Acc = $urandom;
      end
      if (Done) begin
        ndone++;
        if (lat == 0) lat = n;
      end
      if (lat != 0 && n >= lat + 3) break;
    end
    Start = 1'b0;
  endtask

  function automatic logic [31:0] rand_opnd();
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'h1;
      2: return 32'h8000_0000;
      3: return 32'hFFFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int lat, nd;
    logic [67:0] mv;

    #1 reset = 1'b0;
    #1;
    chk_en = 1'b1;
    check("rst_busy", 72'(Busy), 72'd0);
    check("rst_done", 72'(Done), 72'd0);
    check("rst_result", 72'({ResultHi, ResultLo, MulFlags}), 72'd0);
    @(negedge clk);
    reset = 1'b1;

    mv = model_op(2'b11, 32'hFFFF_FFFD, 32'd5, 32'd0);
    check("model_smull", 72'(mv), {4'h0, 4'b1000, 32'hFFFF_FFFF, 32'hFFFF_FFF1});
    mv = model_op(2'b01, 32'h0001_0000, 32'h0001_0000, 32'd5);
    check("model_mla", 72'(mv), {4'h0, 4'b0000, 32'h0, 32'h5});

    run_op(2'b00, 32'd7, 32'd6, 32'd0, 1'b0, lat, nd);
    check("mul7x6_latency", 72'(lat), 72'd35);
    check("mul7x6_res", 72'({MulFlags, ResultHi, ResultLo}), {4'h0, 4'b0000, 32'd0, 32'd42});

    run_op(2'b11, 32'hFFFF_FFFD, 32'd5, 32'd0, 1'b0, lat, nd);
    check("smull_neg", 72'({MulFlags, ResultHi, ResultLo}), {4'h0, 4'b1000, 32'hFFFF_FFFF, 32'hFFFF_FFF1});

    run_op(2'b11, 32'h8000_0000, 32'h8000_0000, 32'd0, 1'b0, lat, nd);
    check("smull_min", 72'({MulFlags, ResultHi, ResultLo}), {4'h0, 4'b0000, 32'h4000_0000, 32'h0});

    run_op(2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 1'b0, lat, nd);
    check("umull_max", 72'({MulFlags, ResultHi, ResultLo}), {4'h0, 4'b1000, 32'hFFFF_FFFE, 32'h1});

    run_op(2'b01, 32'h0001_0000, 32'h0001_0000, 32'd5, 1'b0, lat, nd);
    check("mla_wrap", 72'({MulFlags, ResultHi, ResultLo}), {4'h0, 4'b0000, 32'h0, 32'h5});

    run_op(2'b00, 32'h0, 32'h1234, 32'd0, 1'b0, lat, nd);
    check("mul_zero", 72'({MulFlags, ResultHi, ResultLo}), {4'h0, 4'b0100, 32'h0, 32'h0});

    run_op(2'b00, 32'd1000, 32'd1000, 32'd0, 1'b1, lat, nd);
    check("busy_start_latency", 72'(lat), 72'd35);
    check("busy_start_done_cnt", 72'(nd), 72'd1);
    check("busy_start_res", 72'({ResultHi, ResultLo}), {8'h0, 32'h0, 32'd1000000});

    // asynchronous reset in the middle of a SMULL
    @(negedge clk);
    Start = 1'b1; MulCmd = 2'b11; SrcA = 32'hFFFF_0001; SrcB = 32'h0000_7777;
    @(negedge clk);
    Start = 1'b0;
    repeat (9) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    check("rst_mid_busy", 72'(Busy), 72'd0);
    check("rst_mid_done", 72'(Done), 72'd0);
    check("rst_mid_result", 72'({ResultHi, ResultLo, MulFlags}), 72'd0);
    @(negedge clk);
    reset = 1'b1;
    run_op(2'b00, 32'd3, 32'd3, 32'd0, 1'b0, lat, nd);
    check("mul3x3_after_rst", 72'({ResultHi, ResultLo}), 72'd9);

    for (int i = 0; i < 1500; i++) begin
      @(negedge clk);
      Start  = ($urandom_range(0, 3) == 0);
      MulCmd = 2'($urandom_range(0, 3));
      SrcA   = rand_opnd();
      SrcB   = rand_opnd();
      Acc    = rand_opnd();
    end
    @(negedge clk);
    Start = 1'b0;
    repeat (40) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/mul_unit.md
# mul_unit

Iterative 32×32 multiplier for the multi-cycle processor datapath; it sits beside the ALU/FPU and consumes the controller's multiply-start strobe. It executes MUL, MLA, UMULL and SMULL with a radix-2 shift-add loop. It reports completion with a one-cycle `Done` pulse so the controller can stall its writeback state and write the low and high result words. It also produces N/Z flags in the same nibble layout as `ALUFlags`/`FPUFlags`.

## Interface
Parameters:
- `WIDTH`, 32, operand width; result is 2×`WIDTH`. Only 32 is verified.

Ports:
- `clk`  in  1  clock, rising edge.
- `reset`  in  1  asynchronous, active-low; low = reset.
- `Start`  in  1  start strobe (controller `MulWrite`); sampled only in IDLE.
- `MulCmd`  in  2  00 MUL, 01 MLA, 10 UMULL, 11 SMULL; sampled with `Start`.
- `SrcA`  in  32  multiplicand (Rn); sampled with `Start`.
- `SrcB`  in  32  multiplier (Rm); sampled with `Start`.
- `Acc`  in  32  accumulate operand (Ra), used by MLA only; sampled with `Start`.
- `Busy`  out  1  high in every state except IDLE.
- `Done`  out  1  one-cycle pulse; results are valid from this cycle onward.
- `ResultLo`  out  32  low word (Rd for MUL/MLA, RdLo for long forms).
- `ResultHi`  out  32  high word; 0 for MUL/MLA.
- `MulFlags`  out  4  {N,Z,C,V}; C and V are always 0.

## Operation
- States:
  - IDLE → RUN on `Start`=1. At that edge, latch the command and `Acc`, load the multiplicand and multiplier, and clear the product register and the 5-bit iteration counter.
  - RUN: each edge adds the shifted multiplicand into the 64-bit product when the current multiplier LSB is 1, shifts, and increments the counter. After the 32nd iteration → FIX.
  - FIX: one edge, → DONE. At this edge `ResultLo`/`ResultHi`/`MulFlags` are registered as follows:
    - SMULL: applies sign correction.
    - MLA: adds `Acc`.
    - MUL/MLA: zeroes the high word.
  - DONE: `Done`=1 for exactly one cycle, → IDLE.
- Signed (SMULL): operand magnitudes are used in RUN. In FIX, the 64-bit product is two's-complement negated if the sign of `SrcA` differs from the sign of `SrcB`. 0x80000000 has magnitude 0x80000000 and is handled without overflow.
- MLA: ResultLo = (SrcA×SrcB + Acc) mod 2^32. Long forms do not accumulate.
- Flags:
  - N = bit 31 of ResultLo (MUL/MLA) or bit 31 of ResultHi (long forms).
  - Z = 1 iff the 32-bit (MUL/MLA) or 64-bit (long) result is zero.
- `ResultLo`/`ResultHi`/`MulFlags` hold their values until the FIX edge of the next operation.
- `Start` while `Busy`=1 is ignored: no restart and no operand capture.
- `Start` during the DONE cycle is ignored; the earliest accepted restart is the cycle after DONE.
- Reset (asynchronous, any state): immediately forces state = IDLE, `Busy`=0, `Done`=0, `ResultLo`=`ResultHi`=0, `MulFlags`=0, counter = 0. The in-flight operation is discarded.

## Timing
- Edge E0 accepts `Start`. `Busy`=1 from the cycle after E0.
- RUN iterations occur at E1..E32. FIX is at E33. `Done`=1 in the cycle after E34; results are registered at E34 and visible with `Done`. `Busy` falls after E35.
- Fixed latency: `Done` is asserted 35 cycles after `Start` is sampled, independent of operand values (no early termination).
- All outputs are registered. There is no combinational path from any input to any output.
- Reset release: the first `Start` is sampled at the first rising edge with `reset`=1.

## Structure
- Package `mul_pkg` holds:
  - the `MulCmd` encodings (MUL_OP, MLA_OP, UMULL_OP, SMULL_OP);
  - the state encoding (IDLE, RUN, FIX, DONE);
  - `MUL_ITER`=32.
- The controller's decode logic imports `MulCmd` encodings from `mul_pkg`.
- Single module with no sub-module. The 64-bit negate and accumulate adder are inline in the FIX logic.

## Test plan
- MUL 7×6: `SrcA`=7, `SrcB`=6 → `Done` 35 cycles after `Start`; ResultLo=42, ResultHi=0, N=0, Z=0.
- SMULL 0xFFFFFFFD×5 → ResultHi=0xFFFFFFFF, ResultLo=0xFFFFFFF1, N=1, Z=0.
- SMULL 0x80000000×0x80000000 → ResultHi=0x40000000, ResultLo=0, N=0. Then UMULL 0xFFFFFFFF×0xFFFFFFFF → ResultHi=0xFFFFFFFE, ResultLo=0x00000001.
- MLA 0x10000×0x10000, `Acc`=5 → ResultLo=5 (wrap), ResultHi=0, Z=0. Then MUL 0×0x1234 → ResultLo=0, Z=1.
- `Start` pulsed at cycles 5 and 20 of a running op with different operands → first result unchanged; exactly one `Done` pulse.
- `reset` driven low at cycle 10 of a SMULL → same cycle: `Busy`=0, `Done`=0, results 0. After release, a new MUL 3×3 → ResultLo=9.
